// File: rtl/ftdi_rx_reader.sv
// ftdi_rx_reader
// Read front end for an FT232H in asynchronous 245-FIFO mode. It paces the
// RD# strobes, captures each byte into a two-entry buffer and presents the
// bytes downstream on a valid/ready stream. Every byte carries start and end
// of packet tags for fixed-length packets. A counter of completed packets is
// provided for debug displays.
//
// Ports
//   clock       in   system clock
//   resetN      in   asynchronous reset, active low
//   ftdi_rxf_n  in   FTDI RXF#, low while a byte is available (asynchronous)
//   ftdi_data   in   ADBUS read data, stable while ftdi_rd_n is low
//   ftdi_rd_n   out  FTDI RD#, active low, driven from a flop
//   out_data    out  byte at the head of the buffer
//   out_valid   out  out_data holds a byte
//   out_ready   in   downstream takes the byte when out_valid & out_ready
//   out_sop     out  head byte is byte 0 of a packet
//   out_eop     out  head byte is byte PKT_BYTES-1 of a packet
//   pkt_count   out  packets whose last byte was taken downstream, wraps
module ftdi_rx_reader #(
  parameter int PKT_BYTES   = 254,
  parameter int RD_LOW_CYC  = 3,
  parameter int RD_HIGH_CYC = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       ftdi_rxf_n,
  input  logic [7:0] ftdi_data,
  output logic       ftdi_rd_n,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic [7:0] pkt_count
);

  localparam int CNT_MAX = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RD_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(RD_HIGH_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PKT_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_LOW,
    S_RD_HIGH
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_rd_n;
  logic             w_rd_n_nxt;
  logic             w_push;

  logic [SYNC_STAGES-1:0] r_rxf_sync;
  logic                   w_rxf_s;

  // Buffer entry layout: {sop, eop, data}
  logic [9:0]       r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_pkt_count;

  logic       w_pop;
  logic [9:0] w_entry;
  logic [9:0] w_head;

  assign w_rxf_s = r_rxf_sync[SYNC_STAGES-1];
  assign w_entry = {(r_idx == '0), (r_idx == IDX_LAST), ftdi_data};
  assign w_head  = r_mem[r_rd_ptr];
  assign w_pop   = out_valid & out_ready;

  assign ftdi_rd_n = r_rd_n;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = w_head[7:0];
  // Tags are masked when empty so a stale slot never shows a packet marker.
  assign out_sop   = w_head[9] & out_valid;
  assign out_eop   = w_head[8] & out_valid;
  assign pkt_count = r_pkt_count;

  // RXF# synchroniser; resets to "no data" so nothing is read straight out of reset.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_rxf_sync <= '1;
    end else begin
      r_rxf_sync[0] <= ftdi_rxf_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_rxf_sync[i] <= r_rxf_sync[i-1];
      end
    end
  end

  // Strobe sequencer state register. Reset forces RD# high at once, which
  // abandons any half-finished read.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rd_n  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rd_n  <= w_rd_n_nxt;
    end
  end

  // Buffer space is checked only when a strobe starts. Nothing else can push
  // during the strobe, so the slot seen free here is still free at capture.
  // The RD_HIGH dwell lets the synchroniser flush the stale low RXF# left by
  // the previous byte before IDLE looks at it again.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_n_nxt  = r_rd_n;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxf_s && (r_count < 2'd2)) begin
          w_rd_n_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RD_LOW;
        end
      end
      S_RD_LOW: begin
        if (r_cnt == LOW_LAST) begin
          w_push      = 1'b1;
          w_rd_n_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RD_HIGH;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RD_HIGH: begin
        if (r_cnt == HIGH_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_rd_n_nxt  = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Two-entry buffer, byte index and packet counter. Push and pop in the same
  // cycle leave the count unchanged at any fill level.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_idx       <= '0;
      r_pkt_count <= 8'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= ~r_wr_ptr;
        r_idx           <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_pop && out_eop) begin
        r_pkt_count <= r_pkt_count + 8'd1;
      end
    end
  end

endmodule
